demux_1to8: RTL and testbench



---
 rtl/demux_pkg.sv | 39 +++
 rtl/demux_act_cnt.sv | 39 +++
 rtl/demux_1to8.sv | 72 +++++++
 tb/tb_demux_1to8.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared constants and helpers for the 1-to-N demultiplexer.
// Optional activity counters are enabled by defining DEMUX_ACT_CNT_EN.
package demux_pkg;

    // Default width of each per-output activity counter
    localparam int CNT_W_DEFAULT = 8;

    // Largest supported output count and the select width that covers it
    localparam int MAX_OUT  = 64;
    localparam int SEL_MAXW = 7;

    // Range-checked one-hot decode: bit i is set only when d=1, i<n and sel==i.
    // An unknown sel never matches, so the result stays all zeros.
    function automatic logic [MAX_OUT-1:0] onehot_dec(
        input logic [SEL_MAXW-1:0] sel,
        input logic                d,
        input int                  n
    );
        logic [MAX_OUT-1:0] res;
        res = '0;
        for (int i = 0; i < MAX_OUT; i++) begin
            if (d && (i < n) && (sel == SEL_MAXW'(i))) begin
                res[i] = 1'b1;
            end
        end
        return res;
    endfunction

    // Saturating increment for a counter of the given width (width < 64)
    function automatic logic [63:0] sat_inc(
        input logic [63:0] value,
        input int unsigned width
    );
        logic [63:0] maxVal;
        maxVal = (64'd1 << width) - 64'd1;
        return (value >= maxVal) ? maxVal : (value + 64'd1);
    endfunction

endpackage

// File: rtl/demux_act_cnt.sv
// One saturating activity counter: clear has priority over increment,
// and the count holds at all-ones instead of wrapping.
module demux_act_cnt
    import demux_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins, otherwise saturating increment when active
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = CNT_W'(sat_inc(64'(cnt_q), CNT_W));
        end
    end

    // Counter register with asynchronous clear on reset
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/demux_1to8.sv
// 1-to-N demultiplexer with a zero-latency combinational output, a
// registered copy, a select-range error flag and, when DEMUX_ACT_CNT_EN
// is defined, per-output saturating activity counters.
module demux_1to8
    import demux_pkg::*;
#(
    parameter int N_OUT = 8,
`ifdef DEMUX_ACT_CNT_EN
    parameter int CNT_W = CNT_W_DEFAULT,
`endif
    localparam int SEL_W = $clog2(N_OUT)
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   D,
    input  logic [SEL_W-1:0]       SEL,
    output logic [N_OUT-1:0]       Y,
    output logic [N_OUT-1:0]       Y_Q,
`ifdef DEMUX_ACT_CNT_EN
    input  logic                   CNT_CLR,
    output logic [N_OUT*CNT_W-1:0] ACT_CNT,
`endif
    output logic                   SEL_ERR
);

    logic [N_OUT-1:0] y_d;
    logic [N_OUT-1:0] y_q;
    logic             selErr;

    // Decode D onto the selected output; out-of-range or unknown select gives zeros
    always_comb begin
        y_d = N_OUT'(onehot_dec(SEL_MAXW'(SEL), D, N_OUT));
    end

    // Flag selects that do not address a real output (unknown select also flags)
    always_comb begin
        if (32'(SEL) < N_OUT) begin
            selErr = 1'b0;
        end else begin
            selErr = 1'b1;
        end
    end

    // One-cycle registered copy of the decode, cleared at once by reset
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            y_q <= '0;
        end else begin
            y_q <= y_d;
        end
    end

    assign Y       = y_d;
    assign Y_Q     = y_q;
    assign SEL_ERR = selErr;

`ifdef DEMUX_ACT_CNT_EN
    // One counter per output, counting edges where that output is high
    for (genvar g = 0; g < N_OUT; g++) begin : gen_cnt
        demux_act_cnt #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .CLK   (CLK),
            .RST_N (RST_N),
            .inc_i (y_d[g]),
            .clr_i (CNT_CLR),
            .cnt_o (ACT_CNT[g*CNT_W +: CNT_W])
        );
    end
`endif

endmodule

// File: tb/tb_demux_1to8.sv
// Testbench for demux_1to8: an 8-output instance and a 6-output instance
// (non power of two) checked against a behavioural reference model.
module tb_demux_1to8;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic       D;
    logic [2:0] SEL;
    logic [7:0] Y;
    logic [7:0] Y_Q;
    logic       SEL_ERR;

    logic       D6;
    logic [2:0] SEL6;
    logic [5:0] Y6;
    logic [5:0] Y_Q6;
    logic       SEL_ERR6;

    int tests    = 0;
    int failures = 0;

    logic [63:0] expYq;
    logic [63:0] expYq6;

`ifdef DEMUX_ACT_CNT_EN
    logic        CNT_CLR;
    logic [31:0] ACT_CNT;
    logic        CNT_CLR6;
    logic [23:0] ACT_CNT6;
`endif

    demux_1to8 #(
        .N_OUT (8)
`ifdef DEMUX_ACT_CNT_EN
        , .CNT_W (4)
`endif
    ) dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .D       (D),
        .SEL     (SEL),
        .Y       (Y),
        .Y_Q     (Y_Q),
`ifdef DEMUX_ACT_CNT_EN
        .CNT_CLR (CNT_CLR),
        .ACT_CNT (ACT_CNT),
`endif
        .SEL_ERR (SEL_ERR)
    );

    demux_1to8 #(
        .N_OUT (6)
`ifdef DEMUX_ACT_CNT_EN
        , .CNT_W (4)
`endif
    ) dut6 (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .D       (D6),
        .SEL     (SEL6),
        .Y       (Y6),
        .Y_Q     (Y_Q6),
`ifdef DEMUX_ACT_CNT_EN
        .CNT_CLR (CNT_CLR6),
        .ACT_CNT (ACT_CNT6),
`endif
        .SEL_ERR (SEL_ERR6)
    );

    // Free-running clock
    always #5 CLK = ~CLK;

    // Watchdog so the run can never hang
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference decode: a single bit 1<<sel when D is high and sel is in range
    function automatic logic [63:0] refY(input logic d, input int sel, input int n);
        return (d && sel < n) ? (64'd1 << sel) : 64'd0;
    endfunction

    function automatic logic refErr(input int sel, input int n);
        return (sel >= n) ? 1'b1 : 1'b0;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic d, input logic [2:0] sel,
                                 input logic d6, input logic [2:0] sel6);
        D    = d;
        SEL  = sel;
        D6   = d6;
        SEL6 = sel6;
    endtask

    // Combinational outputs of both instances against the model
    task automatic checkComb(input string tag);
        checkOutput({tag, "_y"},    64'(Y),        refY(D, int'(SEL), 8));
        checkOutput({tag, "_err"},  64'(SEL_ERR),  64'(refErr(int'(SEL), 8)));
        checkOutput({tag, "_y6"},   64'(Y6),       refY(D6, int'(SEL6), 6));
        checkOutput({tag, "_err6"}, 64'(SEL_ERR6), 64'(refErr(int'(SEL6), 6)));
    endtask

    initial begin
        RST_N = 1'b1;
        applyStimulus(1'b0, 3'd0, 1'b0, 3'd0);
`ifdef DEMUX_ACT_CNT_EN
        CNT_CLR  = 1'b0;
        CNT_CLR6 = 1'b0;
`endif
        #2;
        RST_N = 1'b0;
        #1;

        // Reset state
        checkOutput("rst_yq",  64'(Y_Q),  64'd0);
        checkOutput("rst_yq6", 64'(Y_Q6), 64'd0);
        checkOutput("rst_y",   64'(Y),    64'd0);

        // D=0 sweep: outputs stay zero, no error
        for (int n = 0; n < 8; n++) begin
            applyStimulus(1'b0, 3'(n), 1'b0, 3'd0);
            #1;
            checkOutput($sformatf("d0_y_%0d", n),   64'(Y),       64'd0);
            checkOutput($sformatf("d0_err_%0d", n), 64'(SEL_ERR), 64'd0);
        end

        // D=1 sweep: exactly one-hot, also while reset is held
        for (int n = 0; n < 8; n++) begin
            applyStimulus(1'b1, 3'(n), 1'b0, 3'd0);
            #1;
            checkOutput($sformatf("d1_y_%0d", n), 64'(Y), 64'd1 << n);
        end
        checkOutput("rst_hold_yq", 64'(Y_Q), 64'd0);

        // Non power of two: out-of-range select flags an error
        applyStimulus(1'b1, 3'd3, 1'b1, 3'd6);
        #1;
        checkOutput("n6_sel6_y",   64'(Y6),       64'd0);
        checkOutput("n6_sel6_err", 64'(SEL_ERR6), 64'd1);
        applyStimulus(1'b1, 3'd3, 1'b1, 3'd7);
        #1;
        checkOutput("n6_sel7_err", 64'(SEL_ERR6), 64'd1);
        applyStimulus(1'b1, 3'd3, 1'b1, 3'd5);
        #1;
        checkOutput("n6_sel5_y",   64'(Y6),       64'h20);
        checkOutput("n6_sel5_err", 64'(SEL_ERR6), 64'd0);

        // Release reset; the first edge captures the current decode
        @(negedge CLK);
        RST_N = 1'b1;
        #1;
        checkOutput("pre_edge_yq", 64'(Y_Q), 64'd0);
        @(posedge CLK);
        #1;
        checkOutput("edge1_yq", 64'(Y_Q), 64'h08);
        @(negedge CLK);
        SEL = 3'd5;
        #1;
        checkOutput("sel5_pre_yq", 64'(Y_Q), 64'h08);
        @(posedge CLK);
        #1;
        checkOutput("sel5_yq", 64'(Y_Q), 64'h20);

        // Mid-operation reset clears Y_Q at once while Y keeps decoding
        @(negedge CLK);
        SEL = 3'd3;
        @(posedge CLK);
        #1;
        checkOutput("mid_yq", 64'(Y_Q), 64'h08);
        #2;
        RST_N = 1'b0;
        #1;
        checkOutput("async_rst_yq", 64'(Y_Q), 64'd0);
        checkOutput("async_rst_y",  64'(Y),   64'h08);
        @(negedge CLK);
        RST_N = 1'b1;
        #1;
        checkOutput("release_pre_yq", 64'(Y_Q), 64'd0);
        @(posedge CLK);
        #1;
        checkOutput("release_yq", 64'(Y_Q), 64'h08);

        // Randomized traffic with occasional reset pulses
        expYq  = 64'(Y_Q);
        expYq6 = 64'(Y_Q6);
        for (int c = 0; c < 300; c++) begin
            @(negedge CLK);
            applyStimulus(1'($urandom), 3'($urandom), 1'($urandom), 3'($urandom));
            RST_N = ($urandom_range(0, 15) != 0);
            #1;
            if (!RST_N) begin
                expYq  = 64'd0;
                expYq6 = 64'd0;
            end
            checkComb($sformatf("rnd%0d", c));
            checkOutput($sformatf("rnd%0d_yq_hold", c), 64'(Y_Q), expYq);
            @(posedge CLK);
            #1;
            if (RST_N) begin
                expYq  = refY(D, int'(SEL), 8);
                expYq6 = refY(D6, int'(SEL6), 6);
            end
            checkOutput($sformatf("rnd%0d_yq", c),  64'(Y_Q),  expYq);
            checkOutput($sformatf("rnd%0d_yq6", c), 64'(Y_Q6), expYq6);
        end

`ifdef DEMUX_ACT_CNT_EN
        // Counters: clear, saturate on one output, then clear beats increment
        @(negedge CLK);
        RST_N   = 1'b1;
        CNT_CLR = 1'b1;
        applyStimulus(1'b0, 3'd0, 1'b0, 3'd0);
        @(posedge CLK);
        #1;
        checkOutput("cnt_clr0", 64'(ACT_CNT), 64'd0);
        @(negedge CLK);
        CNT_CLR = 1'b0;
        applyStimulus(1'b1, 3'd2, 1'b0, 3'd0);
        repeat (20) @(posedge CLK);
        #1;
        checkOutput("cnt_sat", 64'(ACT_CNT), 64'h0000_0F00);
        @(negedge CLK);
        CNT_CLR = 1'b1;
        @(posedge CLK);
        #1;
        checkOutput("cnt_clr_prio", 64'(ACT_CNT), 64'd0);
        @(negedge CLK);
        CNT_CLR = 1'b0;
        applyStimulus(1'b1, 3'd7, 1'b0, 3'd0);
        repeat (3) @(posedge CLK);
        #1;
        checkOutput("cnt_three", 64'(ACT_CNT), 64'h3000_0000);
        #2;
        RST_N = 1'b0;
        #1;
        checkOutput("cnt_async_rst", 64'(ACT_CNT), 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
